// File: rtl/huc_timer_irq.sv
// huc_timer_irq: memory-mapped 7-bit down-counter timer plus a small IRQ
// combiner for a 65C02-style bus. Read data and hit are registered, so they
// appear one cycle after the address, matching the memory read latency.
module huc_timer_irq #(
    parameter logic [15:0] TIMER_BASE = 16'h0C00,
    parameter logic [15:0] IRQ_BASE   = 16'h1400,
    parameter int          PRESCALE   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  dIn,
    output logic [7:0]  dOut,
    output logic        hit,
    input  logic        irq1,
    input  logic        irq2,
    output logic        irq_out
);

    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    logic [6:0]  reload_q, reload_d;
    logic [6:0]  counter_q, counter_d;
    logic        en_q, en_d;
    logic [15:0] pre_q, pre_d;
    logic [2:0]  mask_q, mask_d;
    logic        tpend_q, tpend_d;
    logic [7:0]  dOut_q, dOut_d;
    logic        hit_q, hit_d;
    logic        irq_q, irq_d;

    logic selReload, selEnable, selMask, selStatus;
    logic tick, underflow;

    assign dOut    = dOut_q;
    assign hit     = hit_q;
    assign irq_out = irq_q;

    // Address decode of the two register windows.
    always_comb begin
        selReload = (addr == TIMER_BASE);
        selEnable = (addr == TIMER_BASE + 16'd1);
        selMask   = (addr == IRQ_BASE + 16'd2);
        selStatus = (addr == IRQ_BASE + 16'd3);
    end

    // Next-state logic: prescaler, counter, register writes and the
    // registered read mux. A timer-register write on a tick edge swallows
    // that tick, and an underflow beats a simultaneous pending-clear.
    always_comb begin
        reload_d  = reload_q;
        counter_d = counter_q;
        en_d      = en_q;
        pre_d     = pre_q;
        mask_d    = mask_q;
        tpend_d   = tpend_q;
        underflow = 1'b0;
        tick      = en_q && (pre_q == 16'd0);

        if (tick) begin
            pre_d = PRE_MAX;
        end else if (en_q) begin
            pre_d = pre_q - 16'd1;
        end

        if (we && selEnable) begin
            en_d = dIn[0];
            if (dIn[0] && !en_q) begin
                counter_d = reload_q;
                pre_d     = PRE_MAX;
            end else if (!dIn[0]) begin
                pre_d = pre_q;
            end
        end else if (we && selReload) begin
            reload_d = dIn[6:0];
        end else if (tick) begin
            if (counter_q == 7'd0) begin
                counter_d = reload_q;
                underflow = 1'b1;
            end else begin
                counter_d = counter_q - 7'd1;
            end
        end

        if (we && selMask) begin
            mask_d = dIn[2:0];
        end
        if (we && selStatus) begin
            tpend_d = 1'b0;
        end
        if (underflow) begin
            tpend_d = 1'b1;
        end

        hit_d  = selReload || selEnable || selMask || selStatus;
        dOut_d = 8'hFF;
        if (selReload || selEnable) begin
            dOut_d = {1'b0, counter_q};
        end else if (selMask) begin
            dOut_d = {5'b0, mask_q};
        end else if (selStatus) begin
            dOut_d = {5'b0, tpend_q, irq1, irq2};
        end

        irq_d = |({tpend_q, irq1, irq2} & ~mask_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            reload_q  <= 7'd0;
            counter_q <= 7'd0;
            en_q      <= 1'b0;
            pre_q     <= PRE_MAX;
            mask_q    <= 3'd0;
            tpend_q   <= 1'b0;
            dOut_q    <= 8'h00;
            hit_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            reload_q  <= reload_d;
            counter_q <= counter_d;
            en_q      <= en_d;
            pre_q     <= pre_d;
            mask_q    <= mask_d;
            tpend_q   <= tpend_d;
            dOut_q    <= dOut_d;
            hit_q     <= hit_d;
            irq_q     <= irq_d;
        end
    end

endmodule
